pc_fetch_unit: RTL and testbench

Fetch-stage program-counter unit; producer side of the PC+4 value the IF/ID pipeline registers latch.
- Holds the PC, issues one request per instruction to instruction memory over a req/ready handshake, and buffers the returned word.
- Presents pc, pc+PC_STEP and the instruction to decode with a valid flag.
- Applies stalls from hazard detection and branch/jump redirects from later stages.

---
 rtl/pc_fetch_unit_if.sv | 21 ++
 rtl/pc_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC unit: requests instructions, buffers them for decode, applies stalls/redirects.
// Define FETCH_PERF_EN to add fetch/squash performance counters.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_i,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_target,
  pc_fetch_unit_if.master         imem,
  output logic                    fetch_valid,
  output logic [31:0]             instr_out,
  output logic [31:0]             pc_out,
  output logic [31:0]             pcinc_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]             perf_fetch_cnt,
  output logic [31:0]             perf_squash_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        pend_valid, pend_valid_next;
  logic [31:0] pend_target, pend_target_next;
  logic [31:0] instr, instr_next;
  logic        valid, valid_next;
  logic        fetch_event;
  logic        squash_event;
  logic [31:0] redirect_pc;

  assign redirect_pc = {redirect_target[31:2], 2'b00};

  assign imem.imem_addr = pc;
  assign imem.imem_req  = (state == REQ);
  assign pc_out         = pc;
  assign pcinc_out      = pc + PC_STEP;
  assign instr_out      = instr;
  assign fetch_valid    = valid;

  // A response that arrives while a redirect is live or pending is wrong-path and is dropped.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    pend_valid_next  = pend_valid;
    pend_target_next = pend_target;
    instr_next       = instr;
    valid_next       = valid;
    fetch_event      = 1'b0;
    squash_event     = 1'b0;

    unique case (state)
      IDLE: begin
        state_next = REQ;
        if (redirect_valid) begin
          pc_next = redirect_pc;
        end
      end

      REQ: begin
        if (!imem.imem_ready) begin
          if (redirect_valid) begin
            pend_valid_next  = 1'b1;
            pend_target_next = redirect_pc;
          end
        end else if (redirect_valid || pend_valid) begin
          pc_next         = redirect_valid ? redirect_pc : pend_target;
          pend_valid_next = 1'b0;
          squash_event    = 1'b1;
        end else begin
          instr_next  = imem.imem_rdata;
          valid_next  = 1'b1;
          state_next  = HOLD;
          fetch_event = 1'b1;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          valid_next   = 1'b0;
          pc_next      = redirect_pc;
          state_next   = REQ;
          squash_event = 1'b1;
        end else if (!stall_i) begin
          valid_next = 1'b0;
          pc_next    = pc + PC_STEP;
          state_next = REQ;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State advances on the falling edge, in step with the IF/ID pipeline registers.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0000_0000;
      instr       <= 32'h0000_0000;
      valid       <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      pend_valid  <= pend_valid_next;
      pend_target <= pend_target_next;
      instr       <= instr_next;
      valid       <= valid_next;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt  <= 32'h0000_0000;
      perf_squash_cnt <= 32'h0000_0000;
    end else begin
      if (fetch_event) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (squash_event) begin
        perf_squash_cnt <= perf_squash_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_events;
  assign unused_events = fetch_event ^ squash_event;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; covers FETCH_PERF_EN counters when defined.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pcinc_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_squash_cnt;
`endif

  int assert_count = 0;
  int fail_count   = 0;

  pc_fetch_unit_if bus ();

  pc_fetch_unit u_dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem            (bus.master),
    .fetch_valid     (fetch_valid),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .pcinc_out       (pcinc_out)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_squash_cnt (perf_squash_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns a word derived from the address so each fetch is distinguishable.
  always_comb bus.imem_rdata = bus.imem_addr ^ 32'hC0DE_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic fv, input logic [31:0] pc, input logic [31:0] pcinc);
    check({tag, ".req"},   32'(bus.imem_req), 32'(req));
    check({tag, ".addr"},  bus.imem_addr,     addr);
    check({tag, ".fv"},    32'(fetch_valid),  32'(fv));
    check({tag, ".pc"},    pc_out,            pc);
    check({tag, ".pcinc"}, pcinc_out,         pcinc);
  endtask

  initial begin
    reset           = 1'b1;
    stall_i         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    bus.imem_ready  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    check("reset.instr", instr_out, 32'h0);

    // Sequential fetch with memory always ready
    tick();
    check_out("seq_req0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h4);
    tick();
    check_out("seq_hold0", 1'b0, 32'h0, 1'b1, 32'h0, 32'h4);
    check("seq_hold0.instr", instr_out, 32'hC0DE_0000);
    tick();
    check_out("seq_req4", 1'b1, 32'h4, 1'b0, 32'h4, 32'h8);
    tick();
    check_out("seq_hold4", 1'b0, 32'h4, 1'b1, 32'h4, 32'h8);
    check("seq_hold4.instr", instr_out, 32'hC0DE_0004);
    tick();
    check_out("seq_req8", 1'b1, 32'h8, 1'b0, 32'h8, 32'hC);

    // Stall held three cycles at PC 8
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall_hold8", 1'b0, 32'h8, 1'b1, 32'h8, 32'hC);
      check("stall_hold8.instr", instr_out, 32'hC0DE_0008);
    end
    stall_i = 1'b0;
    tick();
    check_out("after_stall", 1'b1, 32'hC, 1'b0, 32'hC, 32'h10);
    tick();
    check_out("hold12", 1'b0, 32'hC, 1'b1, 32'hC, 32'h10);
    check("hold12.instr", instr_out, 32'hC0DE_000C);

    // Redirect beats stall in HOLD; low target bits are cleared
    stall_i         = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0103;
    tick();
    check_out("redir_hold", 1'b1, 32'h100, 1'b0, 32'h100, 32'h104);
    redirect_valid = 1'b0;
    stall_i        = 1'b0;
    tick();
    check_out("hold100", 1'b0, 32'h100, 1'b1, 32'h100, 32'h104);
    check("hold100.instr", instr_out, 32'hC0DE_0100);

    // Redirect to 16 with memory stalled, then a second redirect while waiting
    redirect_valid  = 1'b1;
    redirect_target = 32'h10;
    bus.imem_ready  = 1'b0;
    tick();
    redirect_valid = 1'b0;
    check_out("wait16_a", 1'b1, 32'h10, 1'b0, 32'h10, 32'h14);
    tick();
    check_out("wait16_b", 1'b1, 32'h10, 1'b0, 32'h10, 32'h14);
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check_out("wait16_c", 1'b1, 32'h10, 1'b0, 32'h10, 32'h14);
    tick();
    check_out("wait16_d", 1'b1, 32'h10, 1'b0, 32'h10, 32'h14);
    tick();
    check_out("wait16_e", 1'b1, 32'h10, 1'b0, 32'h10, 32'h14);
    bus.imem_ready = 1'b1;
    tick();
    check_out("squash16", 1'b1, 32'h40, 1'b0, 32'h40, 32'h44);
    tick();
    check_out("hold40", 1'b0, 32'h40, 1'b1, 32'h40, 32'h44);
    check("hold40.instr", instr_out, 32'hC0DE_0040);

    // Asynchronous reset mid-cycle while in HOLD
    stall_i = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_out("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    check("async_reset.instr", instr_out, 32'h0);
    tick();
    reset   = 1'b0;
    stall_i = 1'b0;
`ifdef FETCH_PERF_EN
    check("perf_reset.fetch",  perf_fetch_cnt,  32'd0);
    check("perf_reset.squash", perf_squash_cnt, 32'd0);
`endif

    // PC wraparound from the top of the address space
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check_out("wrap_req", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'h0);
    tick();
    check("wrap_hold.instr", instr_out, 32'h3F21_FFFC);
    tick();
    check_out("wrap_next", 1'b1, 32'h0, 1'b0, 32'h0, 32'h4);
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h20;
    tick();
    redirect_valid = 1'b0;
    check_out("perf_squash_req", 1'b1, 32'h20, 1'b0, 32'h20, 32'h24);
    tick();
    check("perf_hold20.instr", instr_out, 32'hC0DE_0020);
`ifdef FETCH_PERF_EN
    check("perf.fetch",  perf_fetch_cnt,  32'd3);
    check("perf.squash", perf_squash_cnt, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
